// File: rtl/melody_sequencer_if.sv
// Control and output bundle between the melody sequencer and its control logic / oscillator.
interface melody_sequencer_if #(
  parameter int unsigned AW = 4
) ();
  logic          WR_EN;
  logic [AW-1:0] WR_ADDR;
  logic [7:0]    WR_DATA;
  logic          START;
  logic          STOP;
  logic          LOOP;
  logic [2:0]    NOTE;
  logic          SOUND_EN;
  logic          BUSY;
  logic [AW-1:0] STEP;
  logic          DONE;

  modport master (
    output WR_EN, WR_ADDR, WR_DATA, START, STOP, LOOP,
    input  NOTE, SOUND_EN, BUSY, STEP, DONE
  );

  modport slave (
    input  WR_EN, WR_ADDR, WR_DATA, START, STOP, LOOP,
    output NOTE, SOUND_EN, BUSY, STEP, DONE
  );
endinterface

// File: rtl/melody_sequencer.sv
// Step sequencer: plays a stored melody as timed notes with articulation gaps,
// driving the oscillator note select and a sound gate.
module melody_sequencer #(
  parameter int unsigned DEPTH     = 16,
  parameter int unsigned TICK_DIV  = 500000,
  parameter int unsigned GAP_TICKS = 1
) (
  input  logic CLK,
  input  logic RST_N,
  melody_sequencer_if.slave bus
);

  localparam int unsigned AW       = $clog2(DEPTH);
  localparam int unsigned PW       = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned TMAX     = (GAP_TICKS + 1 > 16) ? GAP_TICKS + 1 : 16;
  localparam int unsigned TW       = $clog2(TMAX);
  localparam int unsigned GAP_LAST = (GAP_TICKS > 0) ? GAP_TICKS - 1 : 0;

  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
  localparam logic [AW-1:0] STEP_LAST  = AW'(DEPTH - 1);
  localparam logic [AW-1:0] STEP_FIRST = '0;

  typedef enum logic [1:0] {S_IDLE, S_PLAY, S_GAP} state_e;

  typedef struct packed {
    logic       rest;
    logic [2:0] note;
    logic [3:0] dur;
  } entry_t;

  entry_t        mem_q [DEPTH];
  entry_t        mem_d [DEPTH];
  state_e        state_q, state_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [TW-1:0] tcnt_q, tcnt_d;
  logic [2:0]    note_q, note_d;
  logic          snd_q, snd_d;
  logic          busy_q, busy_d;
  logic [AW-1:0] step_q, step_d;
  logic          done_q, done_d;

  entry_t        cur_e, nxt_e, first_e, ld_e;
  logic [AW-1:0] step_nxt, load_idx;
  logic          tick, at_end, advance, load, go_idle;

  // Next-state: STOP wins, then per-state timing, then step advance / reload.
  always_comb begin
    state_d  = state_q;
    presc_d  = presc_q;
    tcnt_d   = tcnt_q;
    note_d   = note_q;
    snd_d    = snd_q;
    busy_d   = busy_q;
    step_d   = step_q;
    done_d   = 1'b0;
    mem_d    = mem_q;
    advance  = 1'b0;
    load     = 1'b0;
    go_idle  = 1'b0;
    load_idx = STEP_FIRST;

    cur_e    = mem_q[step_q];
    step_nxt = step_q + AW'(1);
    nxt_e    = mem_q[step_nxt];
    first_e  = mem_q[STEP_FIRST];
    tick     = (presc_q == PRESC_LAST);
    at_end   = (step_q == STEP_LAST) || (nxt_e.dur == 4'd0);

    if (bus.WR_EN && !busy_q) begin
      mem_d[bus.WR_ADDR] = entry_t'(bus.WR_DATA);
    end

    if (bus.STOP) begin
      go_idle = 1'b1;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus.START) begin
            if (first_e.dur != 4'd0) load = 1'b1;
            else                     done_d = 1'b1;
          end
        end
        S_PLAY: begin
          presc_d = tick ? '0 : presc_q + PW'(1);
          if (tick) begin
            if (tcnt_q == TW'(cur_e.dur - 4'd1)) begin
              if (GAP_TICKS > 0) begin
                state_d = S_GAP;
                snd_d   = 1'b0;
                tcnt_d  = '0;
              end else begin
                advance = 1'b1;
              end
            end else begin
              tcnt_d = tcnt_q + TW'(1);
            end
          end
        end
        S_GAP: begin
          presc_d = tick ? '0 : presc_q + PW'(1);
          if (tick) begin
            if (tcnt_q == TW'(GAP_LAST)) advance = 1'b1;
            else                         tcnt_d  = tcnt_q + TW'(1);
          end
        end
        default: go_idle = 1'b1;
      endcase
    end

    // End of melody either wraps (LOOP) or finishes with a DONE pulse.
    if (advance) begin
      if (!at_end) begin
        load     = 1'b1;
        load_idx = step_nxt;
      end else if (bus.LOOP) begin
        load = 1'b1;
      end else begin
        go_idle = 1'b1;
        done_d  = 1'b1;
      end
    end

    ld_e = mem_q[load_idx];
    if (load) begin
      state_d = S_PLAY;
      step_d  = load_idx;
      note_d  = ld_e.note;
      snd_d   = !ld_e.rest;
      busy_d  = 1'b1;
      presc_d = '0;
      tcnt_d  = '0;
    end

    if (go_idle) begin
      state_d = S_IDLE;
      step_d  = '0;
      note_d  = '0;
      snd_d   = 1'b0;
      busy_d  = 1'b0;
      presc_d = '0;
      tcnt_d  = '0;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= S_IDLE;
      presc_q <= '0;
      tcnt_q  <= '0;
      note_q  <= '0;
      snd_q   <= 1'b0;
      busy_q  <= 1'b0;
      step_q  <= '0;
      done_q  <= 1'b0;
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
    end else begin
      state_q <= state_d;
      presc_q <= presc_d;
      tcnt_q  <= tcnt_d;
      note_q  <= note_d;
      snd_q   <= snd_d;
      busy_q  <= busy_d;
      step_q  <= step_d;
      done_q  <= done_d;
      mem_q   <= mem_d;
    end
  end

  assign bus.NOTE     = note_q;
  assign bus.SOUND_EN = snd_q;
  assign bus.BUSY     = busy_q;
  assign bus.STEP     = step_q;
  assign bus.DONE     = done_q;

endmodule

// File: tb/tb_melody_sequencer.sv
// Bench for melody_sequencer: two instances (GAP_TICKS=1 and 0) share stimulus and
// are checked every cycle against a timeline model plus hand-computed totals.
module tb_melody_sequencer;

  localparam int TD = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       wr_en = 1'b0;
  logic [3:0] wr_addr = '0;
  logic [7:0] wr_data = '0;
  logic       start = 1'b0;
  logic       stop = 1'b0;
  logic       loop_en = 1'b0;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  melody_sequencer_if #(.AW(4)) bus0 ();
  melody_sequencer_if #(.AW(4)) bus1 ();

  assign bus0.WR_EN = wr_en;   assign bus1.WR_EN = wr_en;
  assign bus0.WR_ADDR = wr_addr; assign bus1.WR_ADDR = wr_addr;
  assign bus0.WR_DATA = wr_data; assign bus1.WR_DATA = wr_data;
  assign bus0.START = start;   assign bus1.START = start;
  assign bus0.STOP = stop;     assign bus1.STOP = stop;
  assign bus0.LOOP = loop_en;  assign bus1.LOOP = loop_en;

  melody_sequencer #(.DEPTH(16), .TICK_DIV(TD), .GAP_TICKS(1)) dut0 (
    .CLK(clk), .RST_N(rst_n), .bus(bus0));
  melody_sequencer #(.DEPTH(16), .TICK_DIV(TD), .GAP_TICKS(0)) dut1 (
    .CLK(clk), .RST_N(rst_n), .bus(bus1));

  logic [9:0] got0, got1;
  assign got0 = {bus0.NOTE, bus0.SOUND_EN, bus0.BUSY, bus0.STEP, bus0.DONE};
  assign got1 = {bus1.NOTE, bus1.SOUND_EN, bus1.BUSY, bus1.STEP, bus1.DONE};

  // Model: per instance, memory image, playing flag, step index and cycles elapsed in step.
  int         gap_t [2] = '{1, 0};
  logic [7:0] m_mem [2][16];
  bit         m_busy [2];
  int         m_step [2];
  int         m_t [2];
  bit         m_done [2];

  int c_busy[2], c_aud[2], c_aud0[2], c_done[2], c_s15[2];
  int b_busy[2], b_aud[2], b_aud0[2], b_done[2], b_s15[2];

  task automatic chk(input string name, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
  endtask

  function automatic logic [9:0] got_of(input int i);
    return (i == 0) ? got0 : got1;
  endfunction

  task automatic model_edge();
    for (int i = 0; i < 2; i++) begin
      bit old_busy;
      int dur;
      old_busy  = m_busy[i];
      m_done[i] = 1'b0;
      if (!rst_n) begin
        m_busy[i] = 1'b0; m_step[i] = 0; m_t[i] = 0;
        for (int a = 0; a < 16; a++) m_mem[i][a] = 8'h00;
        continue;
      end
      if (stop) begin
        m_busy[i] = 1'b0; m_step[i] = 0; m_t[i] = 0;
      end else if (!old_busy) begin
        if (start) begin
          if (m_mem[i][0][3:0] != 4'd0) begin
            m_busy[i] = 1'b1; m_step[i] = 0; m_t[i] = 0;
          end else begin
            m_done[i] = 1'b1;
          end
        end
      end else begin
        m_t[i]++;
        dur = int'(m_mem[i][m_step[i]][3:0]);
        if (m_t[i] == (dur + gap_t[i]) * TD) begin
          m_t[i] = 0;
          if (m_step[i] == 15 || m_mem[i][(m_step[i] + 1) % 16][3:0] == 4'd0) begin
            if (loop_en) m_step[i] = 0;
            else begin
              m_busy[i] = 1'b0; m_step[i] = 0; m_done[i] = 1'b1;
            end
          end else begin
            m_step[i]++;
          end
        end
      end
      if (wr_en && !old_busy) m_mem[i][wr_addr] = wr_data;
    end
  endtask

  function automatic logic [9:0] exp_of(input int i);
    logic [7:0] e;
    bit         snd;
    if (!m_busy[i]) return {9'd0, m_done[i]};
    e   = m_mem[i][m_step[i]];
    snd = (m_t[i] < int'(e[3:0]) * TD) && !e[7];
    return {e[6:4], snd, 1'b1, 4'(m_step[i]), m_done[i]};
  endfunction

  task automatic cyc();
    logic [9:0] g;
    @(posedge clk);
    model_edge();
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      g = got_of(i);
      chk($sformatf("cycle_i%0d_t%0t", i, $time), int'(g), int'(exp_of(i)));
      if (g[5])                 c_busy[i]++;
      if (g[6])                 c_aud[i]++;
      if (g[6] && g[9:7] == 0)  c_aud0[i]++;
      if (g[0])                 c_done[i]++;
      if (g[5] && g[4:1] == 15) c_s15[i]++;
    end
  endtask

  task automatic wr(input int a, input int d);
    wr_en = 1'b1; wr_addr = 4'(a); wr_data = 8'(d);
    cyc();
    wr_en = 1'b0;
  endtask

  task automatic start_pulse();
    start = 1'b1;
    cyc();
    start = 1'b0;
  endtask

  task automatic run_until_idle(input int maxc);
    int n;
    n = 0;
    while ((bus0.BUSY || bus1.BUSY) && n < maxc) begin
      cyc();
      n++;
    end
    if (n >= maxc) chk("idle_timeout", int'(bus0.BUSY || bus1.BUSY), 0);
  endtask

  task automatic snap();
    b_busy = c_busy; b_aud = c_aud; b_aud0 = c_aud0; b_done = c_done; b_s15 = c_s15;
  endtask

  task automatic totals(input string tag, input int i, input int busy,
                        input int aud, input int aud0, input int done);
    chk($sformatf("%s_i%0d_busy_cycles", tag, i), c_busy[i] - b_busy[i], busy);
    chk($sformatf("%s_i%0d_audible_cycles", tag, i), c_aud[i] - b_aud[i], aud);
    chk($sformatf("%s_i%0d_note0_audible", tag, i), c_aud0[i] - b_aud0[i], aud0);
    chk($sformatf("%s_i%0d_done_pulses", tag, i), c_done[i] - b_done[i], done);
  endtask

  initial begin
    for (int i = 0; i < 2; i++) begin
      c_busy[i] = 0; c_aud[i] = 0; c_aud0[i] = 0; c_done[i] = 0; c_s15[i] = 0;
    end
    repeat (2) cyc();
    chk("reset_i0", int'(got0), 0);
    chk("reset_i1", int'(got1), 0);
    rst_n = 1'b1;
    cyc();

    // Two-step melody, single pass.
    wr(0, 8'h02); wr(1, 8'h41);
    snap(); start_pulse(); run_until_idle(200);
    totals("basic", 0, 20, 12, 8, 1);
    totals("basic", 1, 12, 12, 8, 1);

    // Rest entry: timed but silent.
    wr(0, 8'hB1); wr(1, 8'h00);
    snap(); start_pulse(); run_until_idle(200);
    totals("rest", 0, 8, 0, 0, 1);
    totals("rest", 1, 4, 0, 0, 1);

    // Looping with a write attempt while busy; LOOP dropped mid second pass.
    wr(0, 8'h02); wr(1, 8'h41);
    loop_en = 1'b1;
    snap(); start_pulse();
    repeat (4) cyc();
    wr(0, 8'h7F);
    repeat (20) cyc();
    loop_en = 1'b0;
    run_until_idle(200);
    totals("loop", 0, 40, 24, 16, 1);
    totals("loop", 1, 36, 36, 24, 1);

    // STOP three cycles into the first PLAY.
    snap(); start_pulse();
    cyc(); cyc();
    stop = 1'b1;
    cyc();
    stop = 1'b0;
    chk("stop_i0_outputs", int'(got0), 0);
    chk("stop_i1_outputs", int'(got1), 0);
    totals("stop", 0, 3, 3, 3, 0);
    totals("stop", 1, 3, 3, 3, 0);

    // STOP and START together in IDLE stay idle.
    snap();
    stop = 1'b1; start = 1'b1;
    cyc();
    stop = 1'b0; start = 1'b0;
    cyc();
    totals("stopstart", 0, 0, 0, 0, 0);
    totals("stopstart", 1, 0, 0, 0, 0);

    // Replay after STOP starts from step 0 with original contents.
    snap(); start_pulse(); run_until_idle(200);
    totals("replay", 0, 20, 12, 8, 1);
    totals("replay", 1, 12, 12, 8, 1);

    // Full memory of one-tick steps: STEP walks 0..15.
    for (int a = 0; a < 16; a++) wr(a, 8'h01 | ((a % 8) << 4));
    snap(); start_pulse(); run_until_idle(400);
    totals("full", 0, 128, 64, 8, 1);
    totals("full", 1, 64, 64, 8, 1);
    chk("full_i0_step15_cycles", c_s15[0] - b_s15[0], 8);
    chk("full_i1_step15_cycles", c_s15[1] - b_s15[1], 4);

    // End marker at entry 0: immediate DONE, never busy.
    wr(0, 8'h00);
    snap(); start_pulse(); cyc();
    totals("empty", 0, 0, 0, 0, 1);
    totals("empty", 1, 0, 0, 0, 1);

    // Asynchronous reset mid-playback clears outputs and memory.
    wr(0, 8'h02);
    start_pulse();
    repeat (3) cyc();
    rst_n = 1'b0;
    #1;
    chk("async_rst_i0", int'(got0), 0);
    chk("async_rst_i1", int'(got1), 0);
    cyc();
    rst_n = 1'b1;
    cyc();
    snap(); start_pulse(); cyc();
    totals("post_rst", 0, 0, 0, 0, 1);
    totals("post_rst", 1, 0, 0, 0, 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/melody_sequencer.md
Name: melody_sequencer

Overview:
Programmable step sequencer that drives the 3-bit note select of the tone oscillator. It plays a short stored melody: for each step it holds a note for a programmed number of ticks, then inserts an articulation gap. Sits between the control logic (buttons/CPU writes) and the oscillator. It generates NOTE plus a SOUND_EN gate that is ANDed with the oscillator's SPKR output.

Parameters:
DEPTH, 16, number of melody steps (power of 2; address width AW = log2(DEPTH))
TICK_DIV, 500000, CLK cycles per duration tick (>=1)
GAP_TICKS, 1, silent ticks inserted after every step (0 = no gap)

Ports:
CLK  input  1  system clock
RST_N  input  1  asynchronous active-low reset
WR_EN  input  1  write one melody entry (accepted only when BUSY=0)
WR_ADDR  input  AW  entry address
WR_DATA  input  8  entry: [7]=rest, [6:4]=note, [3:0]=duration in ticks (0 = end marker)
START  input  1  begin playback at step 0 (level sampled each cycle)
STOP  input  1  abort playback
LOOP  input  1  replay from step 0 instead of finishing
NOTE  output  3  note select to oscillator (0..7)
SOUND_EN  output  1  1 = audible note, 0 = silence
BUSY  output  1  1 while not IDLE
STEP  output  AW  index of the step being played
DONE  output  1  one-cycle pulse on natural completion

Behaviour:
- Reset (async assert, sync release): state IDLE; NOTE=0, SOUND_EN=0, BUSY=0, STEP=0, DONE=0; prescaler and tick counter cleared; all memory entries cleared to 8'h00 (end markers).
- Memory: DEPTH x 8 registers. A write occurs at the clock edge when WR_EN=1 and BUSY=0. WR_EN while BUSY=1 is ignored; memory stays unchanged.
- States: IDLE, PLAY, GAP. All outputs are registered.
- IDLE, START=1, entry0.dur!=0: at that edge go to PLAY with STEP=0, NOTE=entry0.note, SOUND_EN=!entry0.rest, BUSY=1, prescaler=0, tick count=0.
- IDLE, START=1, entry0.dur==0: stay IDLE; DONE=1 for one cycle.
- START while BUSY is ignored.
- Prescaler: counts 0..TICK_DIV-1. A tick fires on the cycle it equals TICK_DIV-1, then it wraps to 0. It is restarted at 0 on every PLAY/GAP entry.
- PLAY: lasts exactly dur*TICK_DIV cycles. On the final tick:
  - if GAP_TICKS>0, go to GAP with SOUND_EN=0 and NOTE held;
  - otherwise advance directly.
- GAP: lasts exactly GAP_TICKS*TICK_DIV cycles, then advance.
- Advance: if STEP==DEPTH-1 or entry[STEP+1].dur==0, the melody is at its end:
  - LOOP=1 (sampled at the advance edge): reload step 0 into PLAY (entry0 is known non-zero);
  - LOOP=0: go to IDLE; NOTE=0, SOUND_EN=0, BUSY=0, STEP=0, DONE=1 for one cycle.
- Advance, not at end: STEP+1, load that entry into PLAY as above.
- STEP never wraps past DEPTH-1 other than via LOOP.
- Rest entries: PLAY timing is unchanged; SOUND_EN=0 and NOTE=entry.note.
- STOP=1 has highest priority, in any state: next edge goes to IDLE with all outputs at reset values. No DONE pulse. Memory is preserved.
- STOP and START asserted together in IDLE: stay IDLE.
- Asserting RST_N low mid-playback clears everything immediately, including memory.
- Timing: SOUND_EN goes high in the first cycle after the edge that samples START. Total step period = (dur+GAP_TICKS)*TICK_DIV cycles. No cycles are lost between steps.

Test Plan:
Use TICK_DIV=4 and GAP_TICKS=1 unless noted.
- Program 0:{0,0,2}, 1:{0,4,1}, 2:end; pulse START. Required: NOTE=0 with SOUND_EN=1 for 8 cycles, then 4 silent cycles; NOTE=4 with SOUND_EN=1 for 4 cycles, then 4 silent cycles; then DONE pulses once, BUSY=0, NOTE=0.
- Rest entry 0:{1,3,1}, 1:end, START. Required: BUSY=1 for 8 cycles, SOUND_EN stays 0 throughout, NOTE=3 during PLAY, then DONE.
- Same program as the first scenario with LOOP=1. Required: after step 1's gap, STEP returns to 0 and NOTE=0 with no idle cycle and no DONE. Then drop LOOP. Required: the next end gives DONE after one more pass.
- Write 8'h7F to address 0 while BUSY=1. Required: entry unchanged, and the current and next pass play the original values.
- Assert STOP 3 cycles into a PLAY. Required: next cycle BUSY=0, SOUND_EN=0, STEP=0, no DONE. A new START replays from step 0.
- Fill all DEPTH entries with dur=1, GAP_TICKS=0, LOOP=0. Required: STEP counts 0..15 at 4 cycles each, then DONE and IDLE. START with entry0 = end marker gives a DONE pulse and BUSY never rises.
